// File: rtl/hex_display_mux.sv
// Time-multiplexed hex display driver: shadowed value/dp, per-digit scan,
// leading-zero blanking and whole-display blink, all outputs registered.
module hex_display_mux #(
    parameter int unsigned NUM_DIGITS  = 4,
    parameter int unsigned REFRESH_DIV = 50000,
    parameter int unsigned BLINK_SCANS = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic                    load,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    blank_lz,
    input  logic                    blink_en,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an
);

    localparam int unsigned VW = 4 * NUM_DIGITS;
    localparam int unsigned RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned IW = (NUM_DIGITS > 1)  ? $clog2(NUM_DIGITS)  : 1;
    localparam int unsigned SW = (BLINK_SCANS > 1) ? $clog2(BLINK_SCANS) : 1;

    logic [RW-1:0]         ref_cnt_q, ref_cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [SW-1:0]         scan_cnt_q, scan_cnt_d;
    logic                  blink_phase_q, blink_phase_d;
    logic [VW-1:0]         shadow_val_q, shadow_val_d;
    logic [NUM_DIGITS-1:0] shadow_dp_q, shadow_dp_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;

    logic                  ref_wrap;
    logic                  idx_wrap;
    logic                  zero_above;
    logic [NUM_DIGITS-1:0] lz;
    logic [3:0]            cur_nib;
    logic                  cur_dp;
    logic                  cur_blank;
    logic                  hide;

    function automatic logic [6:0] glyph(input logic [3:0] nib);
        case (nib)
            4'h0:    glyph = 7'b1000000;
            4'h1:    glyph = 7'b1111001;
            4'h2:    glyph = 7'b0100100;
            4'h3:    glyph = 7'b0110000;
            4'h4:    glyph = 7'b0011001;
            4'h5:    glyph = 7'b0010010;
            4'h6:    glyph = 7'b0000010;
            4'h7:    glyph = 7'b1111000;
            4'h8:    glyph = 7'b0000000;
            4'h9:    glyph = 7'b0011000;
            4'hA:    glyph = 7'b0001000;
            4'hB:    glyph = 7'b0000011;
            4'hC:    glyph = 7'b1000110;
            4'hD:    glyph = 7'b0100001;
            4'hE:    glyph = 7'b0000110;
            default: glyph = 7'b0001110;
        endcase
    endfunction

    // Scan timing: refresh divider, digit index, scan counter and blink phase
    always_comb begin
        ref_wrap      = (ref_cnt_q == RW'(REFRESH_DIV - 1));
        idx_wrap      = (idx_q == IW'(NUM_DIGITS - 1));
        ref_cnt_d     = ref_wrap ? '0 : ref_cnt_q + RW'(1);
        idx_d         = idx_q;
        scan_cnt_d    = scan_cnt_q;
        blink_phase_d = blink_phase_q;
        if (ref_wrap) begin
            idx_d = idx_wrap ? '0 : idx_q + IW'(1);
            if (idx_wrap) begin
                if (scan_cnt_q == SW'(BLINK_SCANS - 1)) begin
                    scan_cnt_d    = '0;
                    blink_phase_d = ~blink_phase_q;
                end else begin
                    scan_cnt_d = scan_cnt_q + SW'(1);
                end
            end
        end
        shadow_val_d = load ? value : shadow_val_q;
        shadow_dp_d  = load ? dp_in : shadow_dp_q;
    end

    // Output path: leading-zero mask, digit select and glyph decode
    always_comb begin
        zero_above = 1'b1;
        lz         = '0;
        for (int i = int'(NUM_DIGITS) - 1; i > 0; i--) begin
            zero_above = zero_above & (shadow_val_q[4*i +: 4] == 4'h0);
            lz[i]      = blank_lz & zero_above;
        end

        cur_nib   = 4'h0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        an_d      = '1;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (idx_q == IW'(i)) begin
                cur_nib   = shadow_val_q[4*i +: 4];
                cur_dp    = shadow_dp_q[i];
                cur_blank = lz[i];
                an_d[i]   = 1'b0;
            end
        end

        hide  = cur_blank | (blink_en & blink_phase_q);
        seg_d = hide ? 7'b1111111 : glyph(cur_nib);
        dp_d  = hide | ~cur_dp;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ref_cnt_q     <= '0;
            idx_q         <= '0;
            scan_cnt_q    <= '0;
            blink_phase_q <= 1'b0;
            shadow_val_q  <= '0;
            shadow_dp_q   <= '0;
            seg_q         <= 7'b1111111;
            dp_q          <= 1'b1;
            an_q          <= '1;
        end else begin
            ref_cnt_q     <= ref_cnt_d;
            idx_q         <= idx_d;
            scan_cnt_q    <= scan_cnt_d;
            blink_phase_q <= blink_phase_d;
            shadow_val_q  <= shadow_val_d;
            shadow_dp_q   <= shadow_dp_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
            an_q          <= an_d;
        end
    end

    assign seg = seg_q;
    assign dp  = dp_q;
    assign an  = an_q;

endmodule

// File: tb/tb_hex_display_mux.sv
// Directed bench for hex_display_mux (4 digits, 4-cycle refresh, 2-scan blink)
// plus a second instance with a 1-cycle refresh.
module tb_hex_display_mux;

    logic        clk;
    logic        rst_n;
    logic [15:0] value;
    logic        load;
    logic [3:0]  dp_in;
    logic        blank_lz;
    logic        blink_en;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;

    logic [15:0] value1;
    logic        load1;
    logic [3:0]  dp_in1;
    logic        blank_lz1;
    logic        blink_en1;
    logic [6:0]  seg1;
    logic        dp1;
    logic [3:0]  an1;

    int n_cmp;
    int n_bad;
    int cyc;

    hex_display_mux #(.NUM_DIGITS(4), .REFRESH_DIV(4), .BLINK_SCANS(2)) dut (
        .clk(clk), .rst_n(rst_n), .value(value), .load(load), .dp_in(dp_in),
        .blank_lz(blank_lz), .blink_en(blink_en), .seg(seg), .dp(dp), .an(an)
    );

    hex_display_mux #(.NUM_DIGITS(4), .REFRESH_DIV(1), .BLINK_SCANS(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .value(value1), .load(load1), .dp_in(dp_in1),
        .blank_lz(blank_lz1), .blink_en(blink_en1), .seg(seg1), .dp(dp1), .an(an1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int target);
        while (cyc < target) tick();
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        load     = 1'b0;
        value    = 16'h0000;
        dp_in    = 4'h0;
        blank_lz = 1'b0;
        blink_en = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (seg !== 7'b1111111) begin n_bad++; $display("FAIL reset_seg got=%b exp=1111111", seg); end
        n_cmp++; if (dp !== 1'b1) begin n_bad++; $display("FAIL reset_dp got=%b exp=1", dp); end
        n_cmp++; if (an !== 4'b1111) begin n_bad++; $display("FAIL reset_an got=%b exp=1111", an); end
        tick();
        n_cmp++; if (an !== 4'b1110) begin n_bad++; $display("FAIL first_an got=%b exp=1110", an); end
        n_cmp++; if (seg !== 7'b1000000) begin n_bad++; $display("FAIL first_seg got=%b exp=1000000", seg); end
    endtask

    task automatic test_scan_12af();
        logic [6:0] tbl [4];
        logic [3:0] ea;
        int d;
        tbl = '{7'b0001110, 7'b0001000, 7'b0100100, 7'b1111001};
        do_reset();
        value = 16'h12AF;
        load  = 1'b1;
        tick();
        load = 1'b0;
        n_cmp++; if (seg !== 7'b1000000) begin n_bad++; $display("FAIL scan_preload_seg got=%b exp=1000000", seg); end
        for (int k = 2; k <= 16; k++) begin
            tick();
            d  = ((cyc - 1) / 4) % 4;
            ea = ~(4'b0001 << d);
            n_cmp++; if (an !== ea) begin n_bad++; $display("FAIL scan_an cyc=%0d got=%b exp=%b", cyc, an, ea); end
            n_cmp++; if (seg !== tbl[d]) begin n_bad++; $display("FAIL scan_seg cyc=%0d got=%b exp=%b", cyc, seg, tbl[d]); end
            n_cmp++; if (dp !== 1'b1) begin n_bad++; $display("FAIL scan_dp cyc=%0d got=%b exp=1", cyc, dp); end
        end
    endtask

    task automatic test_blank_lz();
        logic [6:0] tbl_on [4];
        logic [6:0] tbl_off [4];
        logic [3:0] ea;
        tbl_on  = '{7'b1000000, 7'b0010010, 7'b1111111, 7'b1111111};
        tbl_off = '{7'b1000000, 7'b0010010, 7'b1000000, 7'b1000000};
        do_reset();
        value    = 16'h0050;
        blank_lz = 1'b1;
        load     = 1'b1;
        tick();
        load = 1'b0;
        for (int d = 0; d < 4; d++) begin
            run_to(4 * d + 2);
            ea = ~(4'b0001 << d);
            n_cmp++; if (an !== ea) begin n_bad++; $display("FAIL lz_an d=%0d got=%b exp=%b", d, an, ea); end
            n_cmp++; if (seg !== tbl_on[d]) begin n_bad++; $display("FAIL lz_on_seg d=%0d got=%b exp=%b", d, seg, tbl_on[d]); end
        end
        blank_lz = 1'b0;
        for (int d = 0; d < 4; d++) begin
            run_to(16 + 4 * d + 2);
            n_cmp++; if (seg !== tbl_off[d]) begin n_bad++; $display("FAIL lz_off_seg d=%0d got=%b exp=%b", d, seg, tbl_off[d]); end
        end
    endtask

    task automatic test_zero_dp();
        logic [6:0] tbl [4];
        tbl = '{7'b1000000, 7'b1111111, 7'b1111111, 7'b1111111};
        do_reset();
        value    = 16'h0000;
        dp_in    = 4'b0100;
        blank_lz = 1'b1;
        load     = 1'b1;
        tick();
        load = 1'b0;
        for (int d = 0; d < 4; d++) begin
            run_to(4 * d + 2);
            n_cmp++; if (seg !== tbl[d]) begin n_bad++; $display("FAIL zero_seg d=%0d got=%b exp=%b", d, seg, tbl[d]); end
            n_cmp++; if (dp !== 1'b1) begin n_bad++; $display("FAIL zero_dp d=%0d got=%b exp=1", d, dp); end
        end
        blank_lz = 1'b0;
        run_to(26);
        n_cmp++; if (an !== 4'b1011) begin n_bad++; $display("FAIL dp_an got=%b exp=1011", an); end
        n_cmp++; if (seg !== 7'b1000000) begin n_bad++; $display("FAIL dp_seg got=%b exp=1000000", seg); end
        n_cmp++; if (dp !== 1'b0) begin n_bad++; $display("FAIL dp_lit got=%b exp=0", dp); end
        run_to(30);
        n_cmp++; if (dp !== 1'b1) begin n_bad++; $display("FAIL dp_unlit got=%b exp=1", dp); end
    endtask

    task automatic test_blink();
        do_reset();
        value    = 16'h12AF;
        blink_en = 1'b1;
        load     = 1'b1;
        tick();
        load = 1'b0;
        run_to(10);
        n_cmp++; if (seg !== 7'b0100100) begin n_bad++; $display("FAIL blink_lit10 got=%b exp=0100100", seg); end
        run_to(32);
        n_cmp++; if (seg !== 7'b1111001) begin n_bad++; $display("FAIL blink_lit32 got=%b exp=1111001", seg); end
        run_to(33);
        n_cmp++; if (seg !== 7'b1111111) begin n_bad++; $display("FAIL blink_dark33 got=%b exp=1111111", seg); end
        n_cmp++; if (an !== 4'b1110) begin n_bad++; $display("FAIL blink_an33 got=%b exp=1110", an); end
        n_cmp++; if (dp !== 1'b1) begin n_bad++; $display("FAIL blink_dp33 got=%b exp=1", dp); end
        run_to(40);
        blink_en = 1'b0;
        run_to(41);
        n_cmp++; if (seg !== 7'b0100100) begin n_bad++; $display("FAIL blink_off41 got=%b exp=0100100", seg); end
        run_to(44);
        blink_en = 1'b1;
        run_to(50);
        n_cmp++; if (seg !== 7'b1111111) begin n_bad++; $display("FAIL blink_dark50 got=%b exp=1111111", seg); end
        n_cmp++; if (an !== 4'b1110) begin n_bad++; $display("FAIL blink_an50 got=%b exp=1110", an); end
        run_to(64);
        n_cmp++; if (seg !== 7'b1111111) begin n_bad++; $display("FAIL blink_dark64 got=%b exp=1111111", seg); end
        n_cmp++; if (an !== 4'b0111) begin n_bad++; $display("FAIL blink_an64 got=%b exp=0111", an); end
        run_to(65);
        n_cmp++; if (seg !== 7'b0001110) begin n_bad++; $display("FAIL blink_lit65 got=%b exp=0001110", seg); end
        blink_en = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        value = 16'h12AF;
        load  = 1'b1;
        tick();
        load = 1'b0;
        run_to(10);
        rst_n = 1'b0;
        load  = 1'b1;
        value = 16'hFFFF;
        dp_in = 4'hF;
        tick();
        n_cmp++; if (seg !== 7'b1111111) begin n_bad++; $display("FAIL rmid_seg got=%b exp=1111111", seg); end
        n_cmp++; if (dp !== 1'b1) begin n_bad++; $display("FAIL rmid_dp got=%b exp=1", dp); end
        n_cmp++; if (an !== 4'b1111) begin n_bad++; $display("FAIL rmid_an got=%b exp=1111", an); end
        rst_n = 1'b1;
        load  = 1'b0;
        cyc   = 0;
        tick();
        n_cmp++; if (an !== 4'b1110) begin n_bad++; $display("FAIL rmid_restart_an got=%b exp=1110", an); end
        n_cmp++; if (seg !== 7'b1000000) begin n_bad++; $display("FAIL rmid_restart_seg got=%b exp=1000000", seg); end
        n_cmp++; if (dp !== 1'b1) begin n_bad++; $display("FAIL rmid_restart_dp got=%b exp=1", dp); end
        run_to(6);
        n_cmp++; if (an !== 4'b1101) begin n_bad++; $display("FAIL rmid_d1_an got=%b exp=1101", an); end
        n_cmp++; if (seg !== 7'b1000000) begin n_bad++; $display("FAIL rmid_d1_seg got=%b exp=1000000", seg); end
        n_cmp++; if (dp !== 1'b1) begin n_bad++; $display("FAIL rmid_d1_dp got=%b exp=1", dp); end
        dp_in = 4'h0;
    endtask

    task automatic test_load_on_wrap();
        do_reset();
        value = 16'h12AF;
        load  = 1'b1;
        tick();
        load = 1'b0;
        run_to(15);
        value = 16'h0003;
        load  = 1'b1;
        tick();
        load = 1'b0;
        n_cmp++; if (an !== 4'b0111) begin n_bad++; $display("FAIL wrap_an_old got=%b exp=0111", an); end
        n_cmp++; if (seg !== 7'b1111001) begin n_bad++; $display("FAIL wrap_seg_old got=%b exp=1111001", seg); end
        tick();
        n_cmp++; if (an !== 4'b1110) begin n_bad++; $display("FAIL wrap_an_new got=%b exp=1110", an); end
        n_cmp++; if (seg !== 7'b0110000) begin n_bad++; $display("FAIL wrap_seg_new got=%b exp=0110000", seg); end
    endtask

    task automatic test_load_track();
        logic [15:0] vals [4];
        logic [6:0]  exps [3];
        vals = '{16'h0005, 16'h0009, 16'h000C, 16'h000E};
        exps = '{7'b0010010, 7'b0011000, 7'b1000110};
        do_reset();
        load  = 1'b1;
        value = vals[0];
        tick();
        n_cmp++; if (seg !== 7'b1000000) begin n_bad++; $display("FAIL track_first got=%b exp=1000000", seg); end
        for (int k = 1; k < 4; k++) begin
            value = vals[k];
            tick();
            n_cmp++; if (seg !== exps[k-1]) begin n_bad++; $display("FAIL track_seg k=%0d got=%b exp=%b", k, seg, exps[k-1]); end
        end
        load = 1'b0;
    endtask

    task automatic test_refresh1();
        logic [3:0] ea;
        do_reset();
        for (int k = 1; k <= 8; k++) begin
            tick();
            ea = ~(4'b0001 << ((k - 1) % 4));
            n_cmp++; if (an1 !== ea) begin n_bad++; $display("FAIL div1_an cyc=%0d got=%b exp=%b", k, an1, ea); end
            n_cmp++; if (seg1 !== 7'b1000000) begin n_bad++; $display("FAIL div1_seg cyc=%0d got=%b exp=1000000", k, seg1); end
            n_cmp++; if (dp1 !== 1'b1) begin n_bad++; $display("FAIL div1_dp cyc=%0d got=%b exp=1", k, dp1); end
        end
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        cyc       = 0;
        rst_n     = 1'b0;
        value     = 16'h0000;
        load      = 1'b0;
        dp_in     = 4'h0;
        blank_lz  = 1'b0;
        blink_en  = 1'b0;
        value1    = 16'h0000;
        load1     = 1'b0;
        dp_in1    = 4'h0;
        blank_lz1 = 1'b0;
        blink_en1 = 1'b0;

        test_reset();
        test_scan_12af();
        test_blank_lz();
        test_zero_dp();
        test_blink();
        test_reset_mid();
        test_load_on_wrap();
        test_load_track();
        test_refresh1();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hex_display_mux.md
HEX_DISPLAY_MUX -- requirements
Module: hex_display_mux

Interface
REQ-001 Parameter NUM_DIGITS, default 4: number of multiplexed hex digits, legal range 1-8.
REQ-002 Parameter REFRESH_DIV, default 50000: clock cycles each digit stays selected, legal range 1 to 2^20.
REQ-003 Parameter BLINK_SCANS, default 64: full scans per blink half-period, legal range 1 to 2^16.
REQ-004 clk  input  1: single clock; all state SHALL update on its rising edge.
REQ-005 rst_n  input  1: synchronous active-low reset, sampled on rising clk.
REQ-006 value  input  4*NUM_DIGITS: hex nibbles, digit i = value[4i+3:4i], digit 0 rightmost.
REQ-007 load  input  1: capture value and dp_in into shadow registers.
REQ-008 dp_in  input  NUM_DIGITS: decimal-point request per digit, 1 = lit.
REQ-009 blank_lz  input  1: enable leading-zero blanking.
REQ-010 blink_en  input  1: enable whole-display blinking.
REQ-011 seg  output  7: segments gfedcba, active-low (0 = lit), registered.
REQ-012 dp  output  1: decimal point, active-low, registered.
REQ-013 an  output  NUM_DIGITS: digit enables, active-low one-hot, registered.

Function
REQ-014 On load=1, shadow_val SHALL take value and shadow_dp SHALL take dp_in at that edge; display SHALL read only shadow registers.
REQ-015 Refresh counter SHALL count 0..REFRESH_DIV-1 and wrap to 0; on the wrap cycle digit index SHALL advance by 1, from NUM_DIGITS-1 to 0.
REQ-016 REFRESH_DIV=1: index SHALL advance every cycle.
REQ-017 Scan counter SHALL increment on each index wrap NUM_DIGITS-1 -> 0; on reaching BLINK_SCANS-1 at a wrap it SHALL clear and toggle blink_phase.
REQ-018 Outputs SHALL be registered from the current index and shadow registers: 1 cycle latency from index/shadow change to seg/an/dp.
REQ-019 an SHALL have exactly one bit 0 (position = index) at all times out of reset.
REQ-020 Glyph table (gfedcba): 0=1000000 1=1111001 2=0100100 3=0110000 4=0011001 5=0010010 6=0000010 7=1111000.
REQ-021 Glyph table cont.: 8=0000000 9=0011000 A=0001000 b=0000011 C=1000110 d=0100001 E=0000110 F=0001110.
REQ-022 Digit i SHALL be blanked (seg=1111111, dp=1) when blank_lz=1, i>0, and every nibble i..NUM_DIGITS-1 of shadow_val is 0; digit 0 is never blanked by this rule.
REQ-023 dp for an unblanked digit SHALL be ~shadow_dp[index].
REQ-024 When blink_en=1 and blink_phase=1, seg SHALL be 1111111 and dp 1; an keeps scanning.
REQ-025 blink_en=0 SHALL not stop or reset blink_phase or the scan counter.
REQ-026 load coincident with an index advance: the new shadow SHALL appear in the output registered 1 cycle later, for the new index.
REQ-027 load held continuously SHALL track value every cycle with 1 cycle output latency.

Reset
REQ-028 rst_n=0 at a rising edge SHALL set seg=1111111, dp=1, an=all 1s, index=0, both counters=0, blink_phase=0, shadow_val=0, shadow_dp=0.
REQ-029 Reset mid-scan SHALL take priority over load and counter updates at the same edge.
REQ-030 First edge after rst_n rises SHALL drive an[0]=0 with seg=1000000 (glyph 0).

Verification (NUM_DIGITS=4, REFRESH_DIV=4, BLINK_SCANS=2)
REQ-031 Reset then load value=16'h12AF, dp_in=0 -> an sequences 1110,1101,1011,0111 at 4 cycles each; seg 0001110, 0001000, 0100100, 1111001.
REQ-032 value=16'h0050, blank_lz=1 -> digits 3,2 seg=1111111; digit 1 seg=0010010; digit 0 seg=1000000; with blank_lz=0 digits 3,2 show 1000000.
REQ-033 value=0, blank_lz=1 -> only digit 0 lit (1000000); dp_in=4'b0100 loaded -> digit 2 blanked, dp stays 1.
REQ-034 blink_en=1 -> segments lit for 2 scans (32 cycles), all 1111111 for next 32, an still scanning.
REQ-035 Assert rst_n=0 for 1 cycle mid-digit 2 with load=1 -> all outputs reset values, shadow=0, restart at an=1110 with 1000000.
REQ-036 load pulsed on the index-wrap cycle -> new digit-0 glyph visible exactly 1 cycle later; REFRESH_DIV=1 build -> an changes every cycle.
